// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD line transmitter: FSM encoding,
// mode-byte layout and trailer length.
package memlcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_MODE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_TRAIL = 3'd5,
        ST_HOLD  = 3'd6
    } state_t;

    // Mode byte is shifted MSB first: write flag goes out first, VCOM second.
    localparam logic MODE_WRITE    = 1'b1;
    localparam int   MODE_VCOM_POS = 6;
    localparam int   TRAIL_BITS    = 16;
    localparam int   TRAIL_BYTES   = TRAIL_BITS / 8;

    function automatic logic [7:0] mode_byte(input logic vcom);
        logic [7:0] m;
        m                = 8'h00;
        m[7]             = MODE_WRITE;
        m[MODE_VCOM_POS] = vcom;
        return m;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/memlcd_bitclk.sv
// SCLK half-period timer: CLK_DIV cycles low then CLK_DIV high per bit.
// o_rise/o_fall strobe in the last cycle of each half; i_hold freezes the count.
module memlcd_bitclk #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_hold,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        o_rise  = 1'b0;
        o_fall  = 1'b0;
        if (!i_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (!i_hold) begin
            if (wrap) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                o_rise  = ~phase_q;
                o_fall  = phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/memlcd_line_tx.sv
// Sends one memory-LCD line: mode byte, LSB-first address, FIFO data bytes, 16-bit trailer.
// An empty FIFO at a data byte boundary parks SCLK low with SCS held until the byte arrives.
module memlcd_line_tx
    import memlcd_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int CLK_DIV    = 2,
    parameter int SETUP_CYC  = 4,
    parameter int HOLD_CYC   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_line_addr,
    input  logic       i_vcom,
    input  logic [7:0] i_fifo_rdata,
    input  logic       i_fifo_rempty,
    output logic       o_fifo_rinc,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_lcd_scs,
    output logic       o_lcd_sclk,
    output logic       o_lcd_si
);

    localparam int CYC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CYW     = $clog2(CYC_MAX + 1);
    localparam int BW      = $clog2(LINE_BYTES + TRAIL_BYTES + 1);

    state_t         state_q, state_d;
    logic [CYW-1:0] cyc_q, cyc_d;
    logic [2:0]     bit_q, bit_d;
    logic [BW-1:0]  byte_q, byte_d;
    logic [7:0]     sr_q, sr_d;
    logic [7:0]     addr_q, addr_d;
    logic           vcom_q, vcom_d;
    logic           need_q, need_d;
    logic           done_q, done_d;
    logic           sclk_q, sclk_d;
    logic           rinc;
    logic           shifting;
    logic           fetch_now;
    logic           bc_rise, bc_fall;

    assign shifting  = (state_q == ST_MODE) || (state_q == ST_ADDR) ||
                       (state_q == ST_DATA) || (state_q == ST_TRAIL);
    // need_q marks the first cycle of a data byte whose value is still in the FIFO.
    assign fetch_now = need_q && !i_fifo_rempty;

    memlcd_bitclk #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (shifting),
        .i_hold  (need_q && i_fifo_rempty),
        .o_rise  (bc_rise),
        .o_fall  (bc_fall)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        vcom_d  = vcom_q;
        need_d  = need_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        rinc    = 1'b0;

        if (bc_rise) begin
            sclk_d = 1'b1;
        end else if (bc_fall) begin
            sclk_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SETUP;
                    cyc_d   = '0;
                    addr_d  = i_line_addr;
                    vcom_d  = i_vcom;
                end
            end
            ST_SETUP: begin
                if (cyc_q == CYW'(SETUP_CYC - 1)) begin
                    state_d = ST_MODE;
                    sr_d    = mode_byte(vcom_q);
                    bit_d   = '0;
                    byte_d  = '0;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            ST_MODE, ST_ADDR, ST_DATA, ST_TRAIL: begin
                if (need_q) begin
                    if (fetch_now) begin
                        rinc   = 1'b1;
                        sr_d   = i_fifo_rdata;
                        need_d = 1'b0;
                    end
                end else if (bc_fall) begin
                    if (bit_q != 3'd7) begin
                        sr_d  = {sr_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                    end else begin
                        bit_d = '0;
                        sr_d  = '0;
                        unique case (state_q)
                            ST_MODE: begin
                                state_d = ST_ADDR;
                                sr_d    = rev8(addr_q);
                            end
                            ST_ADDR: begin
                                state_d = ST_DATA;
                                byte_d  = '0;
                                need_d  = 1'b1;
                            end
                            ST_DATA: begin
                                if (byte_q == BW'(LINE_BYTES - 1)) begin
                                    state_d = ST_TRAIL;
                                    byte_d  = '0;
                                end else begin
                                    byte_d = byte_q + BW'(1);
                                    need_d = 1'b1;
                                end
                            end
                            default: begin
                                if (byte_q == BW'(TRAIL_BYTES - 1)) begin
                                    state_d = ST_HOLD;
                                    cyc_d   = '0;
                                end else begin
                                    byte_d = byte_q + BW'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            ST_HOLD: begin
                if (cyc_q == CYW'(HOLD_CYC - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            vcom_q  <= 1'b0;
            need_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            vcom_q  <= vcom_d;
            need_q  <= need_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_lcd_scs   = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_lcd_sclk  = sclk_q;
    assign o_fifo_rinc = rinc;
    // The fetch cycle is already bit 0 of the byte, so the FIFO head drives SI directly.
    assign o_lcd_si    = shifting ? (fetch_now ? i_fifo_rdata[7] : sr_q[7]) : 1'b0;

endmodule

// File: doc/memlcd_line_tx.md
MEMLCD_LINE_TX -- requirements
Module: memlcd_line_tx

Interface
REQ-001 Parameters SHALL be LINE_BYTES (default 16): data bytes per LCD line.
REQ-002 Parameter CLK_DIV (default 2) SHALL set the i_clk cycles per SCLK half-period (CLK_DIV >= 1).
REQ-003 Parameter SETUP_CYC (default 4) SHALL set the cycles between o_lcd_scs rising and the first SCLK rising edge.
REQ-004 Parameter HOLD_CYC (default 4) SHALL set the cycles between the last SCLK falling edge and o_lcd_scs falling.
REQ-005 Ports (one clock; reset is asynchronous and active-low):
 i_clk  in  1  sole clock, LCD-side (FIFO read) domain
 i_rst_n  in  1  asynchronous active-low reset
 i_start  in  1  one-cycle request to transmit one line
 i_line_addr  in  8  gate line address, sampled with i_start
 i_vcom  in  1  VCOM bit, sampled with i_start
 i_fifo_rdata  in  8  FIFO head byte, first-word fall-through
 i_fifo_rempty  in  1  FIFO empty flag
 o_fifo_rinc  out  1  one-cycle pop strobe
 o_busy  out  1  transaction in progress
 o_done  out  1  one-cycle pulse at transaction end
 o_lcd_scs  out  1  LCD chip select, active high
 o_lcd_sclk  out  1  LCD serial clock, idles low
 o_lcd_si  out  1  LCD serial data

Function
REQ-006 The block SHALL accept i_start only in IDLE; i_start while busy SHALL be ignored with no other effect.
REQ-007 States SHALL be IDLE, SETUP, MODE, ADDR, DATA, TRAIL, HOLD, in that order, returning to IDLE.
REQ-008 o_lcd_scs and o_busy SHALL be high from the cycle after i_start is accepted until the cycle HOLD ends.
REQ-009 SETUP SHALL last SETUP_CYC cycles with SCLK low; HOLD SHALL last HOLD_CYC cycles with SCLK low.
REQ-010 Each bit SHALL take 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles; o_lcd_si SHALL change only at a bit-period start (SCLK low).
REQ-011 MODE SHALL send 8 bits, first to last: 1, i_vcom, 0, 0, 0, 0, 0, 0.
REQ-012 ADDR SHALL send i_line_addr LSB first.
REQ-013 DATA SHALL send LINE_BYTES bytes, each MSB first (bit7 = leftmost pixel).
REQ-014 TRAIL SHALL send 16 zero bits.
REQ-015 Unstalled transaction length SHALL be 1 + SETUP_CYC + (32 + 8*LINE_BYTES)*2*CLK_DIV + HOLD_CYC cycles from the i_start cycle to o_done; defaults give 649.
REQ-016 At the start of each DATA byte with i_fifo_rempty low, the block SHALL latch i_fifo_rdata into the shift register and assert o_fifo_rinc for exactly that one cycle.
REQ-017 Underflow: if i_fifo_rempty is high when a DATA byte is due, SCLK SHALL hold low, o_lcd_scs SHALL stay high and the bit counter SHALL freeze until data is available; no byte SHALL be dropped or duplicated.
REQ-018 o_fifo_rinc SHALL never assert while i_fifo_rempty is high or outside DATA; exactly LINE_BYTES pops SHALL occur per transaction.
REQ-019 o_done SHALL pulse for the single cycle in which the state returns to IDLE; a new i_start SHALL be accepted in the following cycle.
REQ-020 The address counter SHALL be 8 bits with no wrap logic; line addresses are the caller's responsibility.

Reset
REQ-021 While i_rst_n is low: state IDLE; o_lcd_scs, o_lcd_sclk, o_lcd_si, o_busy, o_done and o_fifo_rinc SHALL all be 0; counters and shift register SHALL be 0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately: SCS drops, no o_done is issued, and any FIFO bytes already popped are lost.
REQ-023 Reset deassertion SHALL be synchronised externally; the block SHALL take no action until the first i_start after reset.

Structure
REQ-024 State encodings, the mode-byte constants (write bit, VCOM bit position) and the 16-bit trailer length SHALL live in shared package memlcd_pkg.
REQ-025 SCLK half-period timing SHALL be a sub-module memlcd_bitclk, providing a tick counter with rise/fall strobes and a hold (stall) input.

Verification
REQ-026 Reset, then i_start, addr 0x05, vcom 1, FIFO preloaded 16x 0xA5 -> SI shows 1,1,0,0,0,0,0,0; 1,0,1,0,0,0,0,0; 16x 10100101; 16 zeros; o_done at cycle 649.
REQ-027 FIFO empty at DATA byte 3 for 40 cycles -> SCLK low and SCS high during the stall, 16 pops total, byte order preserved.
REQ-028 i_start pulsed at cycle 100 of an active transaction -> ignored; exactly one o_done; second transaction starts only on the next i_start.
REQ-029 i_rst_n low at cycle 300 -> SCS, SCLK, SI and o_busy are 0 the same cycle; no o_done; next i_start runs a full 649-cycle transaction.
REQ-030 Back-to-back i_start in the cycle after o_done, vcom 0 then 1 -> second mode byte is 1,1,0,0,0,0,0,0; SCS low for at least one cycle between the transactions.
REQ-031 CLK_DIV=1, LINE_BYTES=2 -> SCLK period of 2 cycles, 48 bits sent, o_done at cycle 1+4+96+4 = 105.
